// File: rtl/aes_gcm_ctr_top.sv
// GCM counter-mode front end: GHASH-derived J0, AES-128 keystream buffer,
// serial AAD absorption and per-cycle ciphertext emission. Includes the aes128_enc core.

module aes128_enc (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] block,
  output logic         done,
  output logic [127:0] result
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      r = gmul8(r, r);
      r = gmul8(r, x);
    end
    r = gmul8(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = rk[31:0];
    t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte k of the state sits at row k%4, column k/4; byte 0 is the MSB
  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] sb, sr, o;
    logic [7:0]   a0, a1, a2, a3;
    for (int k = 0; k < 16; k++) sb[127-8*k -: 8] = sbox(st[127-8*k -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

  logic [127:0] st_q, rk_q, rk_nxt;
  logic [7:0]   rcon_q;
  logic [3:0]   rnd_q;
  logic         busy_q, done_q;

  assign rk_nxt = key_expand(rk_q, rcon_q);
  assign done   = done_q;
  assign result = st_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= '0;
      rk_q   <= '0;
      rcon_q <= 8'h01;
      rnd_q  <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        st_q   <= block ^ key;
        rk_q   <= key;
        rcon_q <= 8'h01;
        rnd_q  <= 4'd1;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        st_q   <= aes_round(st_q, rk_nxt, rnd_q == 4'd10);
        rk_q   <= rk_nxt;
        rcon_q <= xtime(rcon_q);
        if (rnd_q == 4'd10) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          rnd_q <= rnd_q + 4'd1;
        end
      end
    end
  end

endmodule

module aes_gcm_ctr_top #(
  parameter int MAX_PT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] Key_in,
  input  logic [127:0] IV_in,
  input  logic [31:0]  IV_total,
  input  logic [127:0] PText_in,
  input  logic [31:0]  PText_byte_len,
  input  logic [31:0]  PText_total,
  input  logic [127:0] AAD_in,
  input  logic [31:0]  AAD_total,
  input  logic [127:0] H,
  input  logic [127:0] H2,
  input  logic [127:0] H4,
  output logic         IV_req,
  output logic         PText_req,
  output logic         AAD_req,
  output logic [127:0] CText,
  output logic [31:0]  CText_total
);

  localparam int IW = (MAX_PT > 1) ? $clog2(MAX_PT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_IV, S_AAD, S_KS, S_PT, S_DONE} state_e;

  // GF(2^128) multiply, bit 127 is the x^0 coefficient
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] inc32(input logic [127:0] c);
    return {c[127:32], c[31:0] + 32'd1};
  endfunction

  function automatic logic [127:0] byte_mask(input logic [31:0] len);
    logic [4:0] n;
    logic [7:0] sh;
    n  = (len == 32'd0 || len > 32'd16) ? 5'd16 : len[4:0];
    sh = {5'd16 - n, 3'b000};
    return {128{1'b1}} << sh;
  endfunction

  state_e       state_q, state_d;
  logic [31:0]  cnt_q, cnt_d, iv_n_q, iv_n_d, aad_n_q, aad_n_d, pt_n_q, pt_n_d;
  logic [31:0]  ctot_q, ctot_d;
  logic [127:0] key_q, key_d, h_q, h_d, h2_q, h2_d, h4_q, h4_d;
  logic [127:0] y_q, y_d, s_q, s_d, ctr_q, ctr_d, ctext_q, ctext_d;
  logic         run_q, run_d;
  logic         aes_start, aes_done, ks_we;
  logic [127:0] aes_out;
  logic [127:0] ks_q [MAX_PT];
  logic         unused_hpow;

  // Higher hash-key powers are held for a future parallel GHASH
  assign unused_hpow = ^{h2_q, h4_q};

  aes128_enc u_aes (
    .clk    (clk),
    .rst_n  (rst),
    .start  (aes_start),
    .key    (key_q),
    .block  (inc32(ctr_q)),
    .done   (aes_done),
    .result (aes_out)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    iv_n_d    = iv_n_q;
    aad_n_d   = aad_n_q;
    pt_n_d    = pt_n_q;
    ctot_d    = ctot_q;
    key_d     = key_q;
    h_d       = h_q;
    h2_d      = h2_q;
    h4_d      = h4_q;
    y_d       = y_q;
    s_d       = s_q;
    ctr_d     = ctr_q;
    ctext_d   = ctext_q;
    run_d     = run_q;
    aes_start = 1'b0;
    ks_we     = 1'b0;
    IV_req    = 1'b0;
    AAD_req   = 1'b0;
    PText_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        key_d   = Key_in;
        h_d     = H;
        h2_d    = H2;
        h4_d    = H4;
        iv_n_d  = (IV_total == 32'd0) ? 32'd1 : IV_total;
        aad_n_d = AAD_total;
        pt_n_d  = (PText_total > 32'(MAX_PT)) ? 32'(MAX_PT) : PText_total;
        cnt_d   = '0;
        state_d = S_IV;
      end
      S_IV: begin
        IV_req = (cnt_q == 32'd0);
        y_d    = gf_mul(y_q ^ IV_in, h_q);
        // iv_n data blocks plus the length block
        if (cnt_q == iv_n_q) begin
          cnt_d   = '0;
          ctr_d   = y_d;
          state_d = (aad_n_q == 32'd0) ? S_KS : S_AAD;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_AAD: begin
        AAD_req = (cnt_q == 32'd0);
        s_d     = gf_mul(s_q ^ AAD_in, h_q);
        if (cnt_q == aad_n_q - 32'd1) begin
          cnt_d   = '0;
          state_d = S_KS;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_KS: begin
        if (pt_n_q == 32'd0) begin
          state_d = S_DONE;
        end else if (!run_q) begin
          aes_start = 1'b1;
          ctr_d     = inc32(ctr_q);
          run_d     = 1'b1;
        end else if (aes_done) begin
          ks_we = 1'b1;
          run_d = 1'b0;
          if (cnt_q == pt_n_q - 32'd1) begin
            cnt_d   = '0;
            state_d = S_PT;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_PT: begin
        PText_req = (cnt_q == 32'd0);
        ctext_d   = (PText_in ^ ks_q[cnt_q[IW-1:0]]) & byte_mask(PText_byte_len);
        ctot_d    = ctot_q + 32'd1;
        if (cnt_q == pt_n_q - 32'd1) state_d = S_DONE;
        else cnt_d = cnt_q + 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      iv_n_q  <= '0;
      aad_n_q <= '0;
      pt_n_q  <= '0;
      ctot_q  <= '0;
      key_q   <= '0;
      h_q     <= '0;
      h2_q    <= '0;
      h4_q    <= '0;
      y_q     <= '0;
      s_q     <= '0;
      ctr_q   <= '0;
      ctext_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iv_n_q  <= iv_n_d;
      aad_n_q <= aad_n_d;
      pt_n_q  <= pt_n_d;
      ctot_q  <= ctot_d;
      key_q   <= key_d;
      h_q     <= h_d;
      h2_q    <= h2_d;
      h4_q    <= h4_d;
      y_q     <= y_d;
      s_q     <= s_d;
      ctr_q   <= ctr_d;
      ctext_q <= ctext_d;
      run_q   <= run_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ks_we) ks_q[cnt_q[IW-1:0]] <= aes_out;
  end

  assign CText       = ctext_q;
  assign CText_total = ctot_q;

endmodule

// File: tb/tb_aes_gcm_ctr_top.sv
// Directed bench for aes_gcm_ctr_top built around NIST GCM test case 6.

module tb_aes_gcm_ctr_top;

  typedef struct {
    logic [127:0] pt;
    logic [31:0]  len;
    logic [127:0] ct;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] Key_in = '0, IV_in = '0, PText_in = '0, AAD_in = '0;
  logic [127:0] H = '0, H2 = '0, H4 = '0;
  logic [31:0]  IV_total = '0, PText_byte_len = '0, PText_total = '0, AAD_total = '0;
  logic         IV_req, PText_req, AAD_req;
  logic [127:0] CText;
  logic [31:0]  CText_total;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_iv = 0, n_aad = 0, n_pt = 0;
  int t_iv = 0;
  vec_t tbl [7];
  logic [127:0] iv_blk [5];

  aes_gcm_ctr_top #(.MAX_PT(4)) dut (
    .clk(clk), .rst(rst), .Key_in(Key_in), .IV_in(IV_in), .IV_total(IV_total),
    .PText_in(PText_in), .PText_byte_len(PText_byte_len), .PText_total(PText_total),
    .AAD_in(AAD_in), .AAD_total(AAD_total), .H(H), .H2(H2), .H4(H4),
    .IV_req(IV_req), .PText_req(PText_req), .AAD_req(AAD_req),
    .CText(CText), .CText_total(CText_total)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (IV_req) n_iv <= n_iv + 1;
    if (AAD_req) n_aad <= n_aad + 1;
    if (PText_req) n_pt <= n_pt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_ctext"}, CText, '0);
    chk({nm, "_ctotal"}, {96'h0, CText_total}, 128'd0);
    chk({nm, "_reqs"}, {125'h0, IV_req, AAD_req, PText_req}, 128'd0);
  endtask

  task automatic wait_req(input int which, input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((which == 0 && IV_req) || (which == 1 && AAD_req) || (which == 2 && PText_req)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for request", nm);
    end
  endtask

  task automatic start_msg(input int aad, input int ptt, input int first);
    rst            = 1'b0;
    #1;
    chk_zero_outs("reset_async");
    Key_in         = 128'hfeffe9928665731c6d6a8f9467308308;
    H              = 128'hb83b533708bf535d0aa6e52980d53b78;
    H2             = 128'h0123456789abcdef0123456789abcdef;
    H4             = 128'hfedcba9876543210fedcba9876543210;
    IV_total       = 32'd4;
    AAD_total      = 32'(aad);
    PText_total    = 32'(ptt);
    IV_in          = iv_blk[0];
    AAD_in         = 128'hfeedfacedeadbeeffeedfacedeadbeef;
    PText_in       = tbl[first].pt;
    PText_byte_len = tbl[first].len;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outs("reset_hold");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic feed_iv();
    bit ok;
    wait_req(0, "iv_req", ok);
    if (!ok) return;
    t_iv = cyc;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      // anything after the length block must be ignored
      IV_in = (k < 4) ? iv_blk[k+1] : 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    end
  endtask

  task automatic feed_aad(input int n);
    bit ok;
    if (n == 0) return;
    wait_req(1, "aad_req", ok);
    if (!ok) return;
    chk("aad_after_iv_cycles", 128'(cyc - t_iv), 128'd5);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      AAD_in = 128'h00112233445566778899aabbccddeeff ^ 128'(k);
    end
  endtask

  task automatic feed_pt(input int first, input int n);
    bit ok;
    wait_req(2, "pt_req", ok);
    if (!ok) return;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ctext_v%0d", first + k), CText, tbl[first+k].ct);
      chk($sformatf("ctotal_v%0d", first + k), {96'h0, CText_total}, 128'(k + 1));
      if (k + 1 < n) begin
        PText_in       = tbl[first+k+1].pt;
        PText_byte_len = tbl[first+k+1].len;
      end
    end
  endtask

  task automatic run_msg(input int aad, input int ptt, input int first, input int nfeed);
    int iv0, aad0, pt0;
    start_msg(aad, ptt, first);
    iv0  = n_iv;
    aad0 = n_aad;
    pt0  = n_pt;
    feed_iv();
    feed_aad(aad);
    feed_pt(first, nfeed);
    repeat (8) @(posedge clk);
    #1;
    chk("done_hold_ctext", CText, tbl[first+nfeed-1].ct);
    chk("done_hold_ctotal", {96'h0, CText_total}, 128'(nfeed));
    chk("iv_req_pulses", 128'(n_iv - iv0), 128'd1);
    chk("aad_req_pulses", 128'(n_aad - aad0), (aad > 0) ? 128'd1 : 128'd0);
    chk("pt_req_pulses", 128'(n_pt - pt0), 128'd1);
  endtask

  initial begin
    iv_blk[0] = 128'h9313225df88406e555909c5aff5269aa;
    iv_blk[1] = 128'h6a7a9538534f7da1e4c303d2a318a728;
    iv_blk[2] = 128'hc3c0c95156809539fcf0e2429a6b5254;
    iv_blk[3] = 128'h16aedbf5a0de6a57a637b39b00000000;
    iv_blk[4] = 128'h000000000000000000000000000001e0;
    tbl[0] = '{128'hd9313225f88406e5a55909c5aff5269a, 32'd16, 128'h8ce24998625615b603a033aca13fb894};
    tbl[1] = '{128'h86a7a9531534f7da2e4c303d8a318a72, 32'd16, 128'hbe9112a5c3a211a8ba262a3cca7e2ca7};
    tbl[2] = '{128'h1c3c0c95956809532fcf0e2449a6b525, 32'd16, 128'h01e4a9a4fba43c90ccdcb281d48c7c6f};
    tbl[3] = '{128'hb16aedf5aa0de657ba637b395a5a5a5a, 32'd12, 128'hd62875d2aca417034c34aee500000000};
    tbl[4] = '{128'hd9313225f88406e5a55909c5aff5269a, 32'd1,  {8'h8c, 120'h0}};
    tbl[5] = '{128'hd9313225f88406e5a55909c5aff5269a, 32'd0,  128'h8ce24998625615b603a033aca13fb894};
    tbl[6] = '{128'hd9313225f88406e5a55909c5aff5269a, 32'd17, 128'h8ce24998625615b603a033aca13fb894};

    repeat (2) @(posedge clk);
    #1;
    chk_zero_outs("por");

    run_msg(2, 4, 0, 4);   // TC6 with AAD absorbed
    run_msg(0, 4, 0, 4);   // TC6 without AAD
    run_msg(0, 1, 4, 1);   // single one-byte block
    run_msg(0, 1, 5, 1);   // byte_len 0 means full block
    run_msg(0, 1, 6, 1);   // byte_len 17 means full block
    run_msg(0, 6, 0, 4);   // PText_total clamped to 4

    begin : mid_ks_reset
      int pt0;
      start_msg(0, 4, 0);
      pt0 = n_pt;
      feed_iv();
      repeat (10) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_zero_outs("mid_ks_reset");
      chk("mid_ks_no_pt_req", 128'(n_pt - pt0), 128'd0);
    end

    begin : mid_pt_reset
      bit ok;
      start_msg(0, 4, 0);
      feed_iv();
      wait_req(2, "pt_req_mid", ok);
      if (ok) begin
        @(posedge clk);
        #1;
        chk("mid_pt_first_ct", CText, tbl[0].ct);
        PText_in = tbl[1].pt;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_zero_outs("mid_pt_reset");
      end
    end

    run_msg(0, 4, 0, 4);   // full rerun after aborts

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_gcm_ctr_top.md
# aes_gcm_ctr_top

GCM front-end that turns a streamed IV, AAD and plaintext into ciphertext blocks. It derives the pre-counter block J0 by GHASHing a non-96-bit IV under the supplied hash subkey H. It generates keystream by AES-128-encrypting inc32 counters of J0. It XORs the keystream with the plaintext and emits one ciphertext block per cycle. It sits between the host block streamers (req/data handshake) and the tag stage; AAD is absorbed into an internal GHASH accumulator held for that stage.

## Interface
Parameters:
- MAX_PT, 4, maximum plaintext blocks per message (keystream buffer depth).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- Key_in  in  128  AES-128 key.
- IV_in  in  128  IV block stream, followed by the GHASH length block.
- IV_total  in  32  number of IV data blocks, excluding the length block.
- PText_in  in  128  plaintext block, MSB-first bytes.
- PText_byte_len  in  32  valid bytes in the current plaintext block.
- PText_total  in  32  number of plaintext blocks.
- AAD_in  in  128  AAD block stream.
- AAD_total  in  32  number of AAD blocks.
- H, H2, H4  in  128  each  hash subkey powers. H2 and H4 are latched but unused in this revision (serial GHASH).
- IV_req, PText_req, AAD_req  out  1 each  single-cycle stream-start pulses.
- CText  out  128  last ciphertext block.
- CText_total  out  32  ciphertext blocks emitted.

## Operation
- GF(2^128) multiply uses GCM convention: bit 127 is x^0, reduction constant 0xE1 followed by 120 zero bits. Implement as a combinational function.
- Keystream uses the team core aes128_enc: start/done handshake, one block at a time.
- Input sanitising:
  - IV_total = 0 is treated as 1.
  - PText_total is clamped to MAX_PT.
  - PText_byte_len outside 1..16 is treated as 16.
- FSM states:
  - IDLE: first edge after reset release latches Key_in, H, H2, H4 and the three totals, then goes to IV.
  - IV: pulse IV_req. With Y initialised to 0, perform Y <= (Y ^ IV_in)·H on each of IV_total+1 consecutive sampling edges. Then J0 = Y. Go to AAD.
  - AAD: if AAD_total = 0, skip straight to KS with no AAD_req. Otherwise pulse AAD_req and perform S <= (S ^ AAD_in)·H over AAD_total sampling edges. S is internal only.
  - KS: for i = 1..PText_total, compute ks[i] = AES(K, inc32^i(J0)). inc32 increments the low 32 bits mod 2^32; the upper 96 bits are unchanged.
  - PT: pulse PText_req. On each of PText_total sampling edges:
    - CText <= (PText_in ^ ks[i]) with bytes beyond PText_byte_len forced to 0.
    - CText_total <= CText_total + 1.
  - DONE: hold all outputs until reset.
- PText_total = 0: go DONE without PText_req.

## Timing
- Reset values: IV_req, PText_req and AAD_req are 0; CText is 0; CText_total is 0; the FSM is in IDLE; Y and S are 0. Reset is asynchronous, at any time, and aborts the message.
- Req handshake:
  - The req signal is high for exactly one cycle.
  - Block 1 must already be on the bus and is sampled at the edge that ends the pulse.
  - Each following block is sampled at each subsequent edge, one block per cycle with no stalls.
  - For IV, the stream ends with the length block at the (IV_total+1)-th edge.
- CText and CText_total update at the sampling edge, so they are visible in the following cycle.
- No two req pulses overlap. Streams are served strictly in the order IV, AAD, PT.
- KS latency is PText_total × (aes128_enc latency + 1) cycles. PText_req rises in the cycle after the last keystream block is stored.

## Test plan
- NIST GCM TC6 stimulus:
  - Key feffe9928665731c6d6a8f9467308308, H b83b533708bf535d0aa6e52980d53b78.
  - IV_total 4: 9313225d…, 6a7a9538…, c3c0c951…, 16aedbf5a0de6a57a637b39b00000000, then length block 0…01e0.
  - PText_total 4, last byte_len 12.
  - Required CText sequence: 8ce24998625615b603a033aca13fb894, be9112a5c3a211a8ba262a3cca7e2ca7, 01e4a9a4fba43c90ccdcb281d48c7c6f, d62875d2aca417034c34aee500000000.
  - Required CText_total: 4.
- Reset check: hold rst low -> all outputs 0. Release rst -> exactly one IV_req pulse. Check that IV_in is sampled on exactly IV_total+1 edges.
- AAD_total = 2 -> one AAD_req pulse, and CText values are unchanged from the TC6 scenario. AAD_total = 0 -> AAD_req never rises.
- PText_total = 1 with byte_len 1 -> exactly one CText. Its low 15 bytes are zero and CText_total = 1.
- Assert rst mid-KS -> all outputs return to 0 immediately. After release, a full TC6 rerun produces the same ciphertext.
